// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_pkg
// Description : Shared definitions for the 4x4 keypad scanner: scanner state
//               encoding, 5-bit key codes (bit4 = key held) and helpers that
//               map a (row, col) position to its code.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [4:0] KEY_IDLE  = 5'b00000;
  localparam logic [4:0] KEY_0     = 5'b10000;
  localparam logic [4:0] KEY_1     = 5'b10001;
  localparam logic [4:0] KEY_2     = 5'b10010;
  localparam logic [4:0] KEY_3     = 5'b10011;
  localparam logic [4:0] KEY_4     = 5'b10100;
  localparam logic [4:0] KEY_5     = 5'b10101;
  localparam logic [4:0] KEY_6     = 5'b10110;
  localparam logic [4:0] KEY_7     = 5'b10111;
  localparam logic [4:0] KEY_8     = 5'b11000;
  localparam logic [4:0] KEY_9     = 5'b11001;
  localparam logic [4:0] KEY_A     = 5'b11010;
  localparam logic [4:0] KEY_B     = 5'b11011;
  localparam logic [4:0] KEY_C     = 5'b11100;
  localparam logic [4:0] KEY_D     = 5'b11101;
  localparam logic [4:0] KEY_STAR  = 5'b11110;
  localparam logic [4:0] KEY_SHARP = 5'b11111;

  // Physical layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D
  function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] code;
    case ({row, col})
      4'h0:    code = KEY_1;
      4'h1:    code = KEY_2;
      4'h2:    code = KEY_3;
      4'h3:    code = KEY_A;
      4'h4:    code = KEY_4;
      4'h5:    code = KEY_5;
      4'h6:    code = KEY_6;
      4'h7:    code = KEY_B;
      4'h8:    code = KEY_7;
      4'h9:    code = KEY_8;
      4'hA:    code = KEY_9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = KEY_0;
      4'hE:    code = KEY_SHARP;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Index of the set bit of a one-hot vector (only meaningful for one-hot input)
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module      : keypad_sync
// Description : 4-bit two-flop synchronizer for the asynchronous keypad
//               column returns.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               d_i   - asynchronous input bits
//               q_o   - synchronized output (2 cycles latency)
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 4'b0000;
      sync_q <= 4'b0000;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Active 4x4 matrix keypad scanner. Drives one-hot row strobes,
//               samples the synchronized column returns once per slot,
//               debounces press and release and emits a 5-bit key code with
//               a one-cycle press strobe.
// Ports       : clk       - system clock
//               reset     - synchronous active-high reset
//               col_in    - raw column returns (active high, async)
//               row_out   - one-hot row strobe
//               key       - {held, code}; 5'b00000 when idle
//               key_pulse - one-cycle strobe on accepted press / repeat
// Options     : define KEYPAD_REPEAT_EN to re-fire key_pulse every
//               REPEAT_TICKS slots while a key stays held.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 16,
  parameter int REPEAT_TICKS   = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [4:0] key,
  output logic       key_pulse
);

  localparam int                SLOT_W    = $clog2(SCAN_DIV);
  localparam int                CNT_W     = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  // Counter value whose next matching sample completes the debounce run
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);

  generate
    if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
      $error("keypad_scanner: illegal parameter value");
    end
  endgenerate

  logic [3:0]        col_sync;
  logic [SLOT_W-1:0] slot_q;
  state_e            state_q;
  logic [1:0]        row_idx_q;
  logic [3:0]        row_q;
  logic [1:0]        cand_col_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        key_q;
  logic              pulse_q;

  logic              slot_end;
  logic              smp_valid;
  logic [1:0]        smp_col;
  logic              cand_hit;
  logic              cand_exact;

`ifdef KEYPAD_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
  logic [REP_W-1:0]            rep_q;
`endif

  keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (col_in),
    .q_o   (col_sync)
  );

  assign slot_end   = (slot_q == SLOT_LAST);
  assign smp_valid  = $onehot(col_sync);
  assign smp_col    = onehot_index(col_sync);
  // Pressed/released only looks at the candidate column; debounce needs an exact match
  assign cand_hit   = col_sync[cand_col_q];
  assign cand_exact = (col_sync == (4'b0001 << cand_col_q));

  // The row is frozen (row_idx_q unchanged) from candidate capture until the
  // key is released, so row_idx_q always names the candidate row.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q     <= '0;
      state_q    <= ST_SCAN;
      row_idx_q  <= 2'd0;
      row_q      <= 4'b0001;
      cand_col_q <= 2'd0;
      cnt_q      <= '0;
      key_q      <= KEY_IDLE;
      pulse_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      pulse_q <= 1'b0;
      slot_q  <= slot_end ? '0 : slot_q + 1'b1;
      if (slot_end) begin
        unique case (state_q)
          ST_SCAN: begin
            if (smp_valid) begin
              cand_col_q <= smp_col;
              if (DEBOUNCE_TICKS == 1) begin
                state_q <= ST_PRESSED;
                key_q   <= key_code(row_idx_q, smp_col);
                pulse_q <= 1'b1;
                cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
                rep_q   <= '0;
`endif
              end else begin
                state_q <= ST_DEBOUNCE;
                cnt_q   <= CNT_W'(1);
              end
            end else begin
              row_idx_q <= row_idx_q + 2'd1;
              row_q     <= {row_q[2:0], row_q[3]};
            end
          end
          ST_DEBOUNCE: begin
            if (cand_exact) begin
              if (cnt_q == DB_LAST) begin
                state_q <= ST_PRESSED;
                key_q   <= key_code(row_idx_q, cand_col_q);
                pulse_q <= 1'b1;
                cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
                rep_q   <= '0;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              state_q   <= ST_SCAN;
              cnt_q     <= '0;
              row_idx_q <= row_idx_q + 2'd1;
              row_q     <= {row_q[2:0], row_q[3]};
            end
          end
          ST_PRESSED: begin
            if (!cand_hit) begin
              if (DEBOUNCE_TICKS == 1) begin
                state_q   <= ST_SCAN;
                key_q     <= KEY_IDLE;
                cnt_q     <= '0;
                row_idx_q <= row_idx_q + 2'd1;
                row_q     <= {row_q[2:0], row_q[3]};
              end else begin
                state_q <= ST_RELEASE;
                cnt_q   <= CNT_W'(1);
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_q == REP_LAST) begin
              rep_q   <= '0;
              pulse_q <= 1'b1;
            end else begin
              rep_q <= rep_q + 1'b1;
            end
`endif
          end
          ST_RELEASE: begin
            if (cand_hit) begin
              // Bounce back to held: same key, no new strobe
              state_q <= ST_PRESSED;
              cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
              rep_q   <= '0;
`endif
            end else if (cnt_q == DB_LAST) begin
              state_q   <= ST_SCAN;
              key_q     <= KEY_IDLE;
              cnt_q     <= '0;
              row_idx_q <= row_idx_q + 2'd1;
              row_q     <= {row_q[2:0], row_q[3]};
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign row_out   = row_q;
  assign key       = key_q;
  assign key_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner. A keypad emulator
//               turns a set of pressed keys into column returns for the
//               currently strobed row; a behavioural model derived from the
//               scanning/debounce rules predicts row_out, key and key_pulse
//               every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int REPEAT_TICKS   = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [4:0] key;
  logic       key_pulse;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .REPEAT_TICKS   (REPEAT_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_in    (col_in),
    .row_out   (row_out),
    .key       (key),
    .key_pulse (key_pulse)
  );

  always #5 clk = ~clk;

  int    n_total    = 0;
  int    n_pass     = 0;
  int    dut_pulses = 0;
  bit    chk_en     = 1'b0;
  logic [15:0] pressed;          // bit r*4+c = key at row r, col c is down
  string keymap = "123A456B789C*0#D";

  // ---------------- behavioural model ----------------
  int         m_pos;             // slot position of the next clock edge
  logic [3:0] m_p1, m_p2;        // column values seen 1 and 2 edges ago
  int         m_row;             // row being strobed
  bit         m_held;            // a key is accepted and held
  bit         m_cand;            // a candidate is being confirmed
  bit         m_releasing;       // held key seen missing, confirming release
  int         m_col;             // candidate / held column
  int         m_run;             // length of the current confirming run
  int         m_rep;             // held samples since last strobe
  logic [3:0] exp_row;
  logic [4:0] exp_key;
  logic       exp_pulse;

  function automatic logic [4:0] code_of(input int r, input int c);
    byte ch;
    int  v;
    ch = keymap[r * 4 + c];
    if (ch >= "0" && ch <= "9")      v = ch - "0";
    else if (ch >= "A" && ch <= "D") v = 10 + ch - "A";
    else if (ch == "*")              v = 14;
    else                             v = 15;
    return {1'b1, 4'(v)};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_p1 = 4'b0; m_p2 = 4'b0; m_row = 0;
    m_held = 0; m_cand = 0; m_releasing = 0; m_col = 0; m_run = 0; m_rep = 0;
    exp_row = 4'b0001; exp_key = 5'b0; exp_pulse = 1'b0;
  endtask

  task automatic next_row();
    m_row = (m_row + 1) % 4;
  endtask

  task automatic accept();
    m_held = 1; m_cand = 0; m_releasing = 0; m_run = 0; m_rep = 0;
    exp_key = code_of(m_row, m_col);
    exp_pulse = 1'b1;
  endtask

  task automatic handle_sample(input logic [3:0] s);
    if (m_held && !m_releasing) begin
      if (!s[m_col]) begin
        m_releasing = 1; m_run = 1;
      end else begin
        m_rep++;
`ifdef KEYPAD_REPEAT_EN
        if (m_rep == REPEAT_TICKS) begin
          exp_pulse = 1'b1; m_rep = 0;
        end
`endif
      end
    end else if (m_held) begin
      if (s[m_col]) begin
        m_releasing = 0; m_run = 0; m_rep = 0;
      end else begin
        m_run++;
      end
    end else if (m_cand) begin
      if (s == (4'b0001 << m_col)) m_run++;
      else begin
        m_cand = 0; m_run = 0; next_row();
      end
    end else if ($countones(s) == 1) begin
      m_cand = 1; m_run = 1;
      for (int i = 0; i < 4; i++) if (s[i]) m_col = i;
    end else begin
      next_row();
    end
    if (m_cand && m_run >= DEBOUNCE_TICKS) accept();
    if (m_releasing && m_run >= DEBOUNCE_TICKS) begin
      m_held = 0; m_releasing = 0; m_run = 0;
      exp_key = 5'b0;
      next_row();
    end
  endtask

  task automatic model_tick(input logic [3:0] cin);
    logic [3:0] smp;
    bit         at_end;
    smp    = m_p2;
    at_end = (m_pos == SCAN_DIV - 1);
    m_p2   = m_p1;
    m_p1   = cin;
    m_pos  = (m_pos + 1) % SCAN_DIV;
    exp_pulse = 1'b0;
    if (at_end) handle_sample(smp);
    exp_row = 4'b0001 << m_row;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("row_out", {4'b0, row_out}, {4'b0, exp_row});
      check("key", {3'b0, key}, {3'b0, exp_key});
      check("key_pulse", {7'b0, key_pulse}, {7'b0, exp_pulse});
      if (key_pulse === 1'b1) dut_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [3:0] cols_for(input logic [3:0] rows, input logic [15:0] pm);
    logic [3:0] c;
    c = 4'b0;
    for (int r = 0; r < 4; r++) if (rows[r] === 1'b1) c = c | pm[r*4 +: 4];
    return c;
  endfunction

  task automatic step();
    col_in = cols_for(row_out, pressed);
    @(posedge clk);
    if (reset) model_reset();
    else       model_tick(col_in);
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bounded(input string name, input bit ok, input int bound);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: condition not reached within %0d cycles", name, bound);
  endtask

  task automatic wait_pulse(input string name);
    int n;
    n = 0;
    while (!exp_pulse && n < 200) begin step(); n++; end
    bounded(name, exp_pulse, 200);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_held || m_cand) && n < 200) begin step(); n++; end
    bounded(name, !(m_held || m_cand), 200);
  endtask

  task automatic wait_row_start(input string name, input int r);
    int n;
    n = 0;
    while (!(m_pos == 0 && m_row == r && !m_held && !m_cand) && n < 100) begin step(); n++; end
    bounded(name, (m_pos == 0 && m_row == r), 100);
  endtask

  initial begin
    int p0;
    reset   = 1'b1;
    col_in  = 4'b0;
    pressed = 16'b0;
    model_reset();
    chk_en  = 1'b1;
    steps(2);
    check("reset row_out", {4'b0, row_out}, 8'h01);
    check("reset key", {3'b0, key}, 8'h00);
    check("reset pulse", {7'b0, key_pulse}, 8'h00);
    reset = 1'b0;

    // Idle rotation: one step per 4-cycle slot
    steps(3);  check("scan r0", {4'b0, row_out}, 8'h01);
    steps(1);  check("scan r1", {4'b0, row_out}, 8'h02);
    steps(4);  check("scan r2", {4'b0, row_out}, 8'h04);
    steps(4);  check("scan r3", {4'b0, row_out}, 8'h08);
    steps(4);  check("scan wrap", {4'b0, row_out}, 8'h01);

    // Stable press of '5' (row1, col1)
    pressed = 16'h0020;
    wait_pulse("press 5");
    check("key 5", {3'b0, key}, 8'h15);
    check("row frozen 5", {4'b0, row_out}, 8'h02);
    step();
    check("pulse width", {7'b0, key_pulse}, 8'h00);
    pressed = 16'h0;
    wait_idle("release 5");

    // One-slot bounce on row1
    wait_row_start("align bounce", 1);
    p0 = dut_pulses;
    pressed = 16'h0020;
    steps(4);
    pressed = 16'h0;
    steps(4);
    check("bounce row", {4'b0, row_out}, 8'h04);
    check("bounce key", {3'b0, key}, 8'h00);
    check("bounce pulses", 8'(dut_pulses - p0), 8'd0);

    // Two columns in row0 (col_in=0011) is no key; then '1' alone
    wait_row_start("align multi", 0);
    p0 = dut_pulses;
    pressed = 16'h0003;
    steps(16);
    check("multi key", {3'b0, key}, 8'h00);
    check("multi pulses", 8'(dut_pulses - p0), 8'd0);
    pressed = 16'h0001;
    wait_pulse("press 1");
    check("key 1", {3'b0, key}, 8'h11);
    pressed = 16'h0;
    wait_idle("release 1");

    // '#' with a 2-slot release bounce, then a real release
    pressed = 16'h4000;
    wait_pulse("press #");
    check("key #", {3'b0, key}, 8'h1F);
    p0 = dut_pulses;
    pressed = 16'h0;
    steps(8);
    pressed = 16'h4000;
    steps(4);
    check("# bounce key", {3'b0, key}, 8'h1F);
    check("# bounce pulses", 8'(dut_pulses - p0), 8'd0);
    check("# bounce row", {4'b0, row_out}, 8'h08);
    pressed = 16'h0;
    steps(12);
    check("# released key", {3'b0, key}, 8'h00);
    check("# released row", {4'b0, row_out}, 8'h01);

    // 'A' held for 12 slots after acceptance
    p0 = dut_pulses;
    pressed = 16'h0008;
    wait_pulse("press A");
    check("key A", {3'b0, key}, 8'h1A);
    steps(48);
`ifdef KEYPAD_REPEAT_EN
    check("A repeat pulses", 8'(dut_pulses - p0), 8'd3);
`else
    check("A single pulse", 8'(dut_pulses - p0), 8'd1);
`endif
    pressed = 16'h0;
    wait_idle("release A");

    // Random key activity
    for (int it = 0; it < 250; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 3)      pressed = 16'h0;
      else if (sel <= 8) pressed = 16'h1 << $urandom_range(0, 15);
      else               pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      steps($urandom_range(1, 30));
    end

    // Reset in the middle of a held key discards it
    pressed = 16'h0200;
    wait_pulse("press 8");
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    pressed = 16'h0;
    steps(1);
    check("reset mid key", {3'b0, key}, 8'h00);
    check("reset mid row", {4'b0, row_out}, 8'h01);
    steps(20);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
